// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment scan driver:
//   SEG_OFF    - active-high segment pattern with every segment dark
//   SEG_CODES  - hex digit to segment lookup, bit6=a ... bit0=g, active-high
//   clog2_min1 - counter width helper that never returns less than 1
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b000_0000;

  localparam logic [6:0] SEG_CODES [16] = '{
    7'b111_1110,  // 0
    7'b011_0000,  // 1
    7'b110_1101,  // 2
    7'b111_1001,  // 3
    7'b011_0011,  // 4
    7'b101_1011,  // 5
    7'b101_1111,  // 6
    7'b111_0000,  // 7
    7'b111_1111,  // 8
    7'b111_1011,  // 9
    7'b111_0111,  // A
    7'b001_1111,  // b
    7'b100_1110,  // C
    7'b011_1101,  // d
    7'b100_1111,  // E
    7'b100_0111   // F
  };

  // Bits needed to count 0..n-1; at least 1 so a single-digit bank still
  // gets a legal (constant) index register.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
// Combinational hex nibble to 7-segment decoder (active-high, abcdefg).
//   nibble : hex value 0..F
//   seg    : segment pattern, bit6=a ... bit0=g
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_CODES[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS 7-segment digits. One digit is lit
// per SCAN_DIV-clock slot; the first DEAD clocks of each slot keep all digit
// enables off so the previous digit's segments cannot ghost onto the next.
// Display data is double-buffered and only swapped at a frame boundary.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture din/dp_in/blank_in into the pending buffer
//   din         : hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp_in       : decimal point per digit
//   blank_in    : force digit dark (segments and dp)
//   lzs         : leading-zero suppression, applied live
//   seg, dp     : segment and decimal-point pins of the active digit
//   dig_sel     : one-hot digit enable, or all off during dead time
//   frame_start : one-cycle pulse when the outputs show digit 0, slot clock 0
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD           = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzs,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int IDX_W = clog2_min1(NUM_DIGITS);
  localparam int CNT_W = clog2_min1(SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  // Pin-level "off" patterns used both at reset and for dark digits.
  localparam logic [6:0]            SEG_PIN_OFF = SEG_OFF ^ {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] DIG_PIN_OFF = {NUM_DIGITS{DIG_INV}};

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_end;
  logic             frame_end;

  logic                    pend;
  logic [4*NUM_DIGITS-1:0] pend_din;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic [4*NUM_DIGITS-1:0] act_din;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // ---------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------
  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Double buffer: loads land in pending; the swap to active happens only
  // at a frame boundary so a frame is never drawn from two data sets.
  // A load in the boundary cycle itself stays pending: the swap uses the
  // pre-edge pending contents while the load overwrites them.
  // ---------------------------------------------------------------------
  // NOTE: the buffers are reset (unlike a plain storage array) because their
  // reset contents, all-blank, define what the display shows after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_din   <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      act_din    <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
    end else begin
      if (load) begin
        pend_din   <= din;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend       <= 1'b1;
      end else if (frame_end && pend) begin
        pend <= 1'b0;
      end

      if (frame_end && pend) begin
        act_din   <= pend_din;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Digit selection and leading-zero mask for the current slot
  // ---------------------------------------------------------------------
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_dark;
  logic [NUM_DIGITS-1:0] dig_on;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [6:0]            dec_seg;

  // NOTE: every variable gets a default before the loops so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    dig_on   = '0;
    lz_mask  = '0;
    zero_run = 1'b1;

    // Digit i is a leading zero when it and every digit above it are zero;
    // digit 0 is always shown so a value of zero still reads "0".
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (act_din[4*i +: 4] == 4'h0);
      lz_mask[i] = (i != 0) && zero_run;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = act_din[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_dark  = act_blank[i] | (lzs & lz_mask[i]);
        dig_on[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // ---------------------------------------------------------------------
  // Output registers; polarity is applied last so dark/off is uniform.
  // ---------------------------------------------------------------------
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] dig_next;

  assign seg_next = cur_dark ? SEG_OFF : dec_seg;
  assign dp_next  = !cur_dark && cur_dp;
  // Segments keep showing the slot's digit during dead time; only the
  // digit enables are withheld.
  assign dig_next = (cnt < CNT_DEAD) ? '0 : dig_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg         <= SEG_PIN_OFF;
      dp          <= SEG_INV;
      dig_sel     <= DIG_PIN_OFF;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_next ^ {7{SEG_INV}};
      dp          <= dp_next ^ SEG_INV;
      dig_sel     <= dig_next ^ DIG_PIN_OFF;
      frame_start <= (idx == '0) && (cnt == '0);
    end
  end

endmodule
